// File: rtl/morphology_pkg.sv
// Shared types and constants for the binary morphology datapath.
package morphology_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/frame_beat_counter.sv
// Beat index within the frame being assembled, with clear/load-1/increment controls.
module frame_beat_counter #(
  parameter int unsigned NBeats = 8,
  parameter int unsigned CntW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load1,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            last_beat_c
);

  // Beat index register; clear has priority over load, load over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CntW'(1);
    end else if (inc) begin
      count <= count + CntW'(1);
    end
  end

  assign last_beat_c = (count == CntW'(NBeats - 1));

endmodule

// File: rtl/frame_packer.sv
// Packs a row-major stream of binary pixel beats into one flat Width*Height frame.
module frame_packer
  import morphology_pkg::*;
#(
  parameter int unsigned Width     = 32,
  parameter int unsigned Height    = 32,
  parameter int unsigned BeatWidth = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BeatWidth-1:0]      pixIn,
  input  logic                      pixValid,
  input  logic                      pixSof,
  output logic                      pixReady,
  output logic [Width*Height-1:0]   imageOut,
  output logic                      imageValid,
  input  logic                      imageReady,
  output logic [ERR_CNT_W-1:0]      errCount
);

  localparam int unsigned NBeats = (Width * Height) / BeatWidth;
  localparam int unsigned CntW   = (NBeats > 1) ? $clog2(NBeats) : 1;

  if (((Width * Height) % BeatWidth) != 0) begin : g_bad_beat_width
    $fatal(1, "frame_packer: Width*Height must be a multiple of BeatWidth");
  end

  state_e            state;
  state_e            state_next;
  logic [CntW-1:0]   count;
  logic              last_beat_c;
  logic              cnt_clr;
  logic              cnt_load1;
  logic              cnt_inc;
  logic              wr_en;
  logic [CntW-1:0]   wr_slot;
  logic              err_inc;
  logic              accept;
  logic              take;

  // The first beat of a frame lands in slot 0; a single-beat frame completes immediately.
  localparam state_e SofNext = (NBeats == 1) ? FULL : FILL;

  assign pixReady = rst_n && (state != FULL);
  assign accept   = pixValid && pixReady;
  assign take     = imageValid && imageReady;

  frame_beat_counter #(
    .NBeats (NBeats),
    .CntW   (CntW)
  ) u_beat_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .load1       (cnt_load1),
    .inc         (cnt_inc),
    .count       (count),
    .last_beat_c (last_beat_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, counter controls, slot write decode and error events.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    wr_en      = 1'b0;
    wr_slot    = '0;
    err_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (pixSof) begin
            wr_en      = 1'b1;
            cnt_load1  = 1'b1;
            state_next = SofNext;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (pixSof) begin
            // Resync: abandon the partial frame and restart at slot 0.
            err_inc    = 1'b1;
            wr_en      = 1'b1;
            cnt_load1  = 1'b1;
            state_next = SofNext;
          end else begin
            wr_en   = 1'b1;
            wr_slot = count;
            if (last_beat_c) begin
              cnt_clr    = 1'b1;
              state_next = FULL;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (take) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame storage; no writes can occur while FULL, so the frame stays stable until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imageOut <= '0;
    end else if (wr_en) begin
      for (int s = 0; s < int'(NBeats); s++) begin
        if (wr_slot == CntW'(s)) begin
          imageOut[s*BeatWidth +: BeatWidth] <= pixIn;
        end
      end
    end
  end

  // Frame-valid flag tracks the FULL state as a registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imageValid <= 1'b0;
    end else begin
      imageValid <= (state_next == FULL);
    end
  end

  // Saturating error counter for orphan beats and abandoned partial frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      errCount <= '0;
    end else if (err_inc && (errCount != {ERR_CNT_W{1'b1}})) begin
      errCount <= errCount + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Randomized and directed bench for frame_packer against a queue-based frame model.
module tb_frame_packer;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned BW = 8;
  localparam int unsigned NB = (W * H) / BW;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] pixIn;
  logic          pixValid;
  logic          pixSof;
  logic          pixReady;
  logic [W*H-1:0] imageOut;
  logic          imageValid;
  logic          imageReady;
  logic [7:0]    errCount;

  frame_packer #(
    .Width     (W),
    .Height    (H),
    .BeatWidth (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixIn      (pixIn),
    .pixValid   (pixValid),
    .pixSof     (pixSof),
    .pixReady   (pixReady),
    .imageOut   (imageOut),
    .imageValid (imageValid),
    .imageReady (imageReady),
    .errCount   (errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: beats of the frame in progress, completed frame awaiting pickup, error tally.
  logic [BW-1:0]  m_q[$];
  logic           m_pend;
  logic [W*H-1:0] m_frame;
  int             m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W*H-1:0] assemble();
    logic [W*H-1:0] f;
    f = '0;
    foreach (m_q[k]) f[k*BW +: BW] = m_q[k];
    return f;
  endfunction

  function automatic logic [W*H-1:0] erode3x3(input logic [W*H-1:0] img);
    logic [W*H-1:0] o;
    logic hit;
    o = '0;
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        hit = 1'b1;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr < 0 || r + dr >= int'(H) || c + dc < 0 || c + dc >= int'(W))
              hit = 1'b0;
            else if (!img[(r + dr) * int'(W) + (c + dc)])
              hit = 1'b0;
          end
        end
        o[r * int'(W) + c] = hit;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] sat_err();
    return (m_err > 255) ? 8'd255 : 8'(m_err);
  endfunction

  // One clock of stimulus; the model advances by the spec's accept/take rules.
  task automatic step(input logic v, input logic s, input logic [BW-1:0] p, input logic r);
    logic acc;
    logic take;
    pixValid   = v;
    pixSof     = s;
    pixIn      = p;
    imageReady = r;
    #1;
    check("pix_ready", 64'(pixReady), 64'(!m_pend));
    @(posedge clk);
    #1;
    acc  = v && !m_pend;
    take = m_pend && r;
    if (take) m_pend = 1'b0;
    if (acc) begin
      if (s) begin
        if (m_q.size() > 0) m_err++;
        m_q.delete();
        m_q.push_back(p);
      end else if (m_q.size() > 0) begin
        m_q.push_back(p);
      end else begin
        m_err++;
      end
      if (m_q.size() == int'(NB)) begin
        m_frame = assemble();
        m_pend  = 1'b1;
        m_q.delete();
      end
    end
    check("image_valid", 64'(imageValid), 64'(m_pend));
    check("err_count", 64'(errCount), 64'(sat_err()));
    if (m_pend) check("image_out", 64'(imageOut), 64'(m_frame));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pixValid   = 1'($urandom);
    pixSof     = 1'($urandom);
    pixIn      = 8'($urandom);
    imageReady = 1'($urandom);
    #1;
    check("ready_in_reset", 64'(pixReady), 64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_q.delete();
    m_pend = 1'b0;
    m_err  = 0;
    check("rst_valid", 64'(imageValid), 64'd0);
    check("rst_image", 64'(imageOut), 64'd0);
    check("rst_err", 64'(errCount), 64'd0);
  endtask

  task automatic send_frame(input logic [63:0] img, input logic r);
    for (int k = 0; k < int'(NB); k++) begin
      step(1'b1, (k == 0), img[k*BW +: BW], r);
    end
  endtask

  logic [63:0] img;
  logic [63:0] held;

  initial begin
    rst_n = 1'b0; pixValid = 1'b0; pixSof = 1'b0; pixIn = '0; imageReady = 1'b0;
    m_pend = 1'b0; m_err = 0; m_frame = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Nominal diagonal frame, then backpressure for 20 cycles with ignored beats.
    send_frame(64'h8040_2010_0804_0201, 1'b0);
    check("diag_valid", 64'(imageValid), 64'd1);
    check("diag_image", 64'(imageOut), 64'h8040_2010_0804_0201);
    held = imageOut;
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    check("bp_stable", 64'(imageOut), held);
    check("bp_err", 64'(errCount), 64'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    send_frame(64'h0123_4567_89AB_CDEF, 1'b0);
    check("next_image", 64'(imageOut), 64'h0123_4567_89AB_CDEF);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Resync after three beats.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, (k == 0), 8'h5A, 1'b1);
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("resync_err", 64'(errCount), 64'd1);
    check("resync_image", 64'(imageOut), 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Orphan beats in IDLE, then a legal frame.
    do_reset();
    step(1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    check("orphan_err", 64'(errCount), 64'd2);
    check("orphan_valid", 64'(imageValid), 64'd0);
    send_frame(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    check("orphan_image", 64'(imageOut), 64'hDEAD_BEEF_CAFE_F00D);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-fill after four beats.
    for (int k = 0; k < 4; k++) step(1'b1, (k == 0), 8'h77, 1'b0);
    do_reset();
    send_frame(64'h0F0F_F0F0_3C3C_C3C3, 1'b0);
    check("postrst_image", 64'(imageOut), 64'h0F0F_F0F0_3C3C_C3C3);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Error saturation, then a 4x4 square eroded by a full 3x3 mask.
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    check("sat_err", 64'(errCount), 64'd255);
    send_frame(64'h0000_3C3C_3C3C_0000, 1'b0);
    img = imageOut;
    check("erode", erode3x3(img), 64'h0000_0018_1800_0000);
    check("sat_err_hold", 64'(errCount), 64'd255);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      else step(($urandom_range(9) < 7), ($urandom_range(11) == 0), 8'($urandom),
                ($urandom_range(1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
